// File: rtl/systolic_host_link_if.sv
// Host <-> systolic-array link bundle: job request, operand beats out, result beats back.
// master = the link itself, slave = the host/array environment around it.
interface systolic_host_link_if;
  logic         start;
  logic [127:0] a_mat;
  logic [127:0] b_mat;
  logic         mat_valid_out;
  logic [63:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [63:0]  rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [511:0] result;
  logic         result_valid;
  logic         done;
  logic         timeout_err;
  logic         busy;

  modport master (
    input  start, a_mat, b_mat, tx_ready, rx_data, rx_valid,
    output mat_valid_out, tx_data, tx_valid, rx_ready,
    output result, result_valid, done, timeout_err, busy
  );

  modport slave (
    output start, a_mat, b_mat, tx_ready, rx_data, rx_valid,
    input  mat_valid_out, tx_data, tx_valid, rx_ready,
    input  result, result_valid, done, timeout_err, busy
  );
endinterface

// File: rtl/systolic_host_link.sv
// Sends one 4x4 int8 job to the array as 4 operand beats, gathers 8 result beats, 14 cycles unstalled.
// tx holds its beat until tx_ready; rx stalls freely but a RECV idle of TIMEOUT cycles aborts the job.
module systolic_host_link #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_host_link_if.master lnk
);
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, SEND, RECV, DONE} state_t;

  state_t         state_q;
  logic [127:0]   a_q;
  logic [127:0]   b_q;
  logic [2:0]     cnt_q;
  logic [WdW-1:0] wd_q;
  logic [63:0]    res_q [8];
  logic           mat_valid_q;
  logic           tx_valid_q;
  logic           rx_ready_q;
  logic           result_valid_q;
  logic           done_q;
  logic           timeout_err_q;
  logic           busy_q;

  logic [7:0] a_el [4][4];
  logic [7:0] b_el [4][4];
  logic [1:0] k;
  logic       tx_fire;
  logic       rx_fire;

  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      assign a_el[i][j] = a_q[127-8*(4*i+j) -: 8];
      assign b_el[i][j] = b_q[127-8*(4*i+j) -: 8];
    end
  end

  // Beat k carries row k of A followed by column k of B.
  assign k       = cnt_q[1:0];
  assign tx_fire = tx_valid_q & lnk.tx_ready;
  assign rx_fire = rx_ready_q & lnk.rx_valid;

  assign lnk.tx_data       = {a_el[k][0], a_el[k][1], a_el[k][2], a_el[k][3],
                              b_el[0][k], b_el[1][k], b_el[2][k], b_el[3][k]};
  assign lnk.result        = {res_q[0], res_q[1], res_q[2], res_q[3],
                              res_q[4], res_q[5], res_q[6], res_q[7]};
  assign lnk.mat_valid_out = mat_valid_q;
  assign lnk.tx_valid      = tx_valid_q;
  assign lnk.rx_ready      = rx_ready_q;
  assign lnk.result_valid  = result_valid_q;
  assign lnk.done          = done_q;
  assign lnk.timeout_err   = timeout_err_q;
  assign lnk.busy          = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      cnt_q          <= '0;
      wd_q           <= '0;
      res_q          <= '{default: '0};
      mat_valid_q    <= 1'b0;
      tx_valid_q     <= 1'b0;
      rx_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      mat_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lnk.start) begin
            a_q            <= lnk.a_mat;
            b_q            <= lnk.b_mat;
            result_valid_q <= 1'b0;
            mat_valid_q    <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= START;
          end
        end
        START: begin
          cnt_q      <= '0;
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (tx_fire) begin
            if (cnt_q == 3'd3) begin
              cnt_q      <= '0;
              wd_q       <= '0;
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= RECV;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        RECV: begin
          if (rx_fire) begin
            res_q[cnt_q] <= lnk.rx_data;
            wd_q         <= '0;
            if (cnt_q == 3'd7) begin
              cnt_q          <= '0;
              rx_ready_q     <= 1'b0;
              result_valid_q <= 1'b1;
              done_q         <= 1'b1;
              state_q        <= DONE;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end else if (wd_q == WdW'(TIMEOUT - 1)) begin
            // The TIMEOUT-th idle cycle ends the job; result_valid stays low.
            wd_q          <= '0;
            cnt_q         <= '0;
            rx_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_host_link.sv
// Directed bench: a table of jobs run against an array model that multiplies the operands it receives,
// plus hand-written reset, timeout and ignored-start sequences. Two instances: TIMEOUT=1024 and TIMEOUT=16.
`timescale 1ns/1ps
module tb_systolic_host_link;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start, tx_ready, rx_valid;
  logic [127:0] a_mat, b_mat;
  logic [63:0]  rx_data;
  bit           sel;

  systolic_host_link_if lk ();
  systolic_host_link_if lt ();

  systolic_host_link #(.TIMEOUT(1024)) dut   (.clk(clk), .reset(reset), .lnk(lk.master));
  systolic_host_link #(.TIMEOUT(16))   dut_t (.clk(clk), .reset(reset), .lnk(lt.master));

  assign lk.start = start;  assign lk.a_mat = a_mat;  assign lk.b_mat = b_mat;
  assign lk.tx_ready = tx_ready;  assign lk.rx_valid = rx_valid;  assign lk.rx_data = rx_data;
  assign lt.start = start;  assign lt.a_mat = a_mat;  assign lt.b_mat = b_mat;
  assign lt.tx_ready = tx_ready;  assign lt.rx_valid = rx_valid;  assign lt.rx_data = rx_data;

  logic         o_mat_valid, o_tx_valid, o_rx_ready, o_result_valid, o_done, o_timeout_err, o_busy;
  logic [63:0]  o_tx_data;
  logic [511:0] o_result;
  always_comb begin
    o_mat_valid    = sel ? lt.mat_valid_out : lk.mat_valid_out;
    o_tx_valid     = sel ? lt.tx_valid      : lk.tx_valid;
    o_tx_data      = sel ? lt.tx_data       : lk.tx_data;
    o_rx_ready     = sel ? lt.rx_ready      : lk.rx_ready;
    o_result       = sel ? lt.result        : lk.result;
    o_result_valid = sel ? lt.result_valid  : lk.result_valid;
    o_done         = sel ? lt.done          : lk.done;
    o_timeout_err  = sel ? lt.timeout_err   : lk.timeout_err;
    o_busy         = sel ? lt.busy          : lk.busy;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] el(input logic [127:0] m, input int i, input int j);
    logic [127:0] t;
    t = m << (8 * (4 * i + j));
    return t[127:120];
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] w, input int b);
    logic [63:0] t;
    t = w << (8 * b);
    return t[63:56];
  endfunction

  function automatic logic [63:0] beat_of(input logic [127:0] a, input logic [127:0] b, input int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = {r[55:0], el(a, k, i)};
    for (int i = 0; i < 4; i++) r = {r[55:0], el(b, i, k)};
    return r;
  endfunction

  function automatic logic [511:0] matmul(input logic [127:0] a, input logic [127:0] b);
    logic [511:0] r;
    int acc;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += int'($signed(el(a, i, k))) * int'($signed(el(b, k, j)));
        r = {r[479:0], acc};
      end
    return r;
  endfunction

  // The array: rebuild A and B from the four beats actually sent, return A*B.
  function automatic logic [511:0] array_model(input logic [255:0] cb);
    logic [127:0] ar, br;
    logic [255:0] t;
    ar = '0;
    br = '0;
    for (int k = 0; k < 4; k++) begin
      t = cb << (64 * k);
      for (int i = 0; i < 4; i++) ar = {ar[119:0], byte_of(t[255:192], i)};
    end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        t = cb << (64 * k);
        br = {br[119:0], byte_of(t[255:192], 4 + i)};
      end
    return matmul(ar, br);
  endfunction

  int          r_done_cyc, r_done_cnt, r_to_cyc, r_to_cnt, r_mv_cnt, r_last_acc, r_tx_bad;
  logic [63:0] r_tx0;
  logic        r_busy_end, r_rv_start;

  // Edge 0 is the posedge that samples start; done latency counts cycles after it, the done cycle included.
  task automatic run_job(input logic [127:0] a, input logic [127:0] b, input int stall_beat,
                         input int stall_len, input int rx_gap, input int rx_stop, input bit poke);
    logic [255:0] cap;
    logic [511:0] ret, t;
    int n, k, j, stalls, gap, post;
    bit poked;
    cap = '0; ret = '0; k = 0; j = 0; stalls = 0; gap = 0; post = -1; poked = 0;
    r_done_cyc = -1; r_done_cnt = 0; r_to_cyc = -1; r_to_cnt = 0; r_mv_cnt = 0;
    r_last_acc = -1; r_tx_bad = 0; r_tx0 = '0;
    @(negedge clk);
    a_mat = a; b_mat = b; start = 1'b1; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
    @(negedge clk);
    n = 0;
    r_rv_start = o_result_valid;
    while (n < 300 && post != 0) begin
      if (o_mat_valid) r_mv_cnt++;
      if (o_done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) r_done_cyc = n + 1;
      end
      if (o_timeout_err) begin
        r_to_cnt++;
        if (r_to_cyc < 0) r_to_cyc = n;
      end
      if ((o_done || o_timeout_err) && post < 0) post = 3;
      start = 1'b0;
      tx_ready = 1'b1;
      if (o_tx_valid) begin
        if (k > 3 || o_tx_data !== beat_of(a, b, k)) r_tx_bad++;
        if (k == 0) r_tx0 = o_tx_data;
        if (k == stall_beat && stalls < stall_len) begin
          tx_ready = 1'b0;
          stalls++;
        end else if (k < 4) begin
          cap = {cap[191:0], o_tx_data};
          k++;
          if (k == 4) ret = array_model(cap);
        end
      end
      if (o_rx_ready) begin
        if (j < rx_stop && gap == 0) begin
          t = ret << (64 * j);
          rx_valid = 1'b1; rx_data = t[511:448];
          j++; gap = rx_gap; r_last_acc = n + 1;
        end else begin
          rx_valid = 1'b0; rx_data = 64'hBAD0_BAD0_BAD0_BAD0;
          if (gap > 0) gap--;
        end
        if (poke && !poked) begin
          start = 1'b1; a_mat = ~a; poked = 1;
        end
      end else begin
        rx_valid = 1'b1; rx_data = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (post > 0) post--;
      @(negedge clk);
      n++;
    end
    r_busy_end = o_busy;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 512'(o_busy), 512'd0);
    check({tag, "_result_valid"}, 512'(o_result_valid), 512'd0);
    check({tag, "_done"}, 512'(o_done), 512'd0);
    check({tag, "_timeout_err"}, 512'(o_timeout_err), 512'd0);
    check({tag, "_mat_valid"}, 512'(o_mat_valid), 512'd0);
    check({tag, "_tx_valid"}, 512'(o_tx_valid), 512'd0);
    check({tag, "_rx_ready"}, 512'(o_rx_ready), 512'd0);
    check({tag, "_tx_data"}, 512'(o_tx_data), 512'd0);
    check({tag, "_result"}, o_result, 512'd0);
  endtask

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    int           stall_beat;
    int           stall_len;
    int           rx_gap;
    bit           poke;
    logic [63:0]  exp_tx0;
    int           exp_lat;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, required finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [127:0] id_a, seq_b;
    id_a  = 128'h01000000_00010000_00000100_00000001;
    seq_b = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    vecs[0] = '{id_a, seq_b, -1, 0, 0, 1'b0, 64'h01000000_0004080C, 14};
    vecs[1] = '{id_a, seq_b, 1, 3, 0, 1'b0, 64'h01000000_0004080C, 17};
    vecs[2] = '{128'hFF020304_05060708_090A0B0C_0D0E0F10, 128'h807F01FE_11223344_55667788_99AABBCC,
                -1, 0, 5, 1'b0, 64'hFF020304_80115599, 49};
    vecs[3] = '{{16{8'h80}}, {16{8'h7F}}, 3, 2, 0, 1'b1, 64'h80808080_7F7F7F7F, 16};

    sel = 1'b0; start = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
    a_mat = '0; b_mat = '0; reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start_with_reset_busy", 512'(o_busy), 512'd0);

    for (int v = 0; v < 4; v++) begin
      run_job(vecs[v].a, vecs[v].b, vecs[v].stall_beat, vecs[v].stall_len, vecs[v].rx_gap, 8, vecs[v].poke);
      check($sformatf("v%0d_tx0", v), 512'(r_tx0), 512'(vecs[v].exp_tx0));
      check($sformatf("v%0d_tx_beats_bad", v), 512'(r_tx_bad), 512'd0);
      check($sformatf("v%0d_done_latency", v), 512'(r_done_cyc), 512'(vecs[v].exp_lat));
      check($sformatf("v%0d_done_pulses", v), 512'(r_done_cnt), 512'd1);
      check($sformatf("v%0d_mat_valid_pulses", v), 512'(r_mv_cnt), 512'd1);
      check($sformatf("v%0d_timeout_pulses", v), 512'(r_to_cnt), 512'd0);
      check($sformatf("v%0d_rv_at_start", v), 512'(r_rv_start), 512'd0);
      check($sformatf("v%0d_result", v), o_result, matmul(vecs[v].a, vecs[v].b));
      check($sformatf("v%0d_result_valid", v), 512'(o_result_valid), 512'd1);
      check($sformatf("v%0d_busy_after", v), 512'(r_busy_end), 512'd0);
      if (v == 0) begin
        check("identity_y00", 512'(o_result[511:480]), 512'd0);
        check("identity_y33", 512'(o_result[31:0]), 512'd15);
      end
    end

    sel = 1'b1;
    run_job(vecs[0].a, vecs[0].b, -1, 0, 0, 3, 1'b0);
    check("to_pulses", 512'(r_to_cnt), 512'd1);
    check("to_delay_after_beat2", 512'(r_to_cyc - r_last_acc), 512'd16);
    check("to_done_pulses", 512'(r_done_cnt), 512'd0);
    check("to_busy", 512'(r_busy_end), 512'd0);
    check("to_result_valid", 512'(o_result_valid), 512'd0);

    sel = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_in_recv");
    reset = 1'b0;

    a_mat = vecs[2].a; b_mat = vecs[2].b; start = 1'b1; tx_ready = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("send_beat2_before_reset", 512'(o_tx_data), 512'(beat_of(vecs[2].a, vecs[2].b, 2)));
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_in_send");
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done || o_timeout_err || o_busy) pulses++;
    end
    check("after_abort_activity", 512'(pulses), 512'd0);

    run_job(vecs[2].a, vecs[2].b, -1, 0, 0, 8, 1'b0);
    check("rerun_done_latency", 512'(r_done_cyc), 512'd14);
    check("rerun_tx_beats_bad", 512'(r_tx_bad), 512'd0);
    check("rerun_result", o_result, matmul(vecs[2].a, vecs[2].b));
    check("rerun_result_valid", 512'(o_result_valid), 512'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
